// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/16-scan sequencer: shifts a row pair, blanks, latches, displays, and swaps
// frame buffers only at frame boundaries. Optional SCAN_DIM_EN adds a brightness input.
module hub75_scan_ctrl #(
  parameter int unsigned COLS         = 64,
  parameter int unsigned ROWS         = 16,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned ON_CYCLES    = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     swap_req_i,
  input  logic [2:0]               pix_top_i,
  input  logic [2:0]               pix_bot_i,
`ifdef SCAN_DIM_EN
  input  logic [2:0]               brightness_i,
`endif
  output logic                     pix_rd_en_o,
  output logic [$clog2(COLS)-1:0]  pix_col_o,
  output logic [$clog2(ROWS)-1:0]  pix_row_o,
  output logic                     frame_sel_o,
  output logic                     swap_ack_o,
  output logic                     frame_done_o,
  output logic [$clog2(ROWS)-1:0]  row_addr_o,
  output logic [2:0]               rgb0_o,
  output logic [2:0]               rgb1_o,
  output logic                     panel_clk_o,
  output logic                     lat_o,
  output logic                     oe_o
);

  localparam int unsigned ColW     = $clog2(COLS);
  localparam int unsigned RowW     = $clog2(ROWS);
  localparam int unsigned ShiftLen = 2 * COLS + 2;
  localparam int unsigned CntW     = $clog2(ShiftLen + ON_CYCLES + BLANK_CYCLES);

  typedef enum logic [2:0] {StIdle, StShift, StBlank, StLatch, StDisplay} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [RowW-1:0]   row_addr_q, row_addr_d;
  logic [2:0]        rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic              frame_sel_q, frame_sel_d;
  logic              swap_ack_q, swap_ack_d;
  logic              frame_done_q, frame_done_d;
`ifdef SCAN_DIM_EN
  logic [2:0]        bright_q, bright_d;
  logic [CntW-1:0]   on_len;
  assign on_len = CntW'(ON_CYCLES >> 3) * (CntW'(bright_q) + CntW'(1));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      row_q        <= '0;
      row_addr_q   <= '0;
      rgb0_q       <= '0;
      rgb1_q       <= '0;
      frame_sel_q  <= 1'b0;
      swap_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SCAN_DIM_EN
      bright_q     <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      row_addr_q   <= row_addr_d;
      rgb0_q       <= rgb0_d;
      rgb1_q       <= rgb1_d;
      frame_sel_q  <= frame_sel_d;
      swap_ack_q   <= swap_ack_d;
      frame_done_q <= frame_done_d;
`ifdef SCAN_DIM_EN
      bright_q     <= bright_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    row_addr_d   = row_addr_q;
    rgb0_d       = rgb0_q;
    rgb1_d       = rgb1_q;
    frame_sel_d  = frame_sel_q;
    swap_ack_d   = 1'b0;
    frame_done_d = 1'b0;
`ifdef SCAN_DIM_EN
    bright_d     = bright_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StShift;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      StShift: begin
        // Frame-store data for the read issued last cycle is valid on odd phases.
        if (cnt_q[0] && cnt_q < CntW'(2 * COLS)) begin
          rgb0_d = pix_top_i;
          rgb1_d = pix_bot_i;
        end
        if (cnt_q == CntW'(ShiftLen - 1)) begin
          state_d    = StBlank;
          cnt_d      = '0;
          row_addr_d = row_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBlank: begin
        if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
          state_d  = StLatch;
          cnt_d    = '0;
`ifdef SCAN_DIM_EN
          bright_d = brightness_i;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLatch: begin
        state_d = StDisplay;
        cnt_d   = '0;
      end
      StDisplay: begin
        if (cnt_q == CntW'(ON_CYCLES - 1)) begin
          cnt_d = '0;
          if (row_q == RowW'(ROWS - 1)) begin
            row_d        = '0;
            frame_done_d = 1'b1;
            if (swap_req_i) begin
              frame_sel_d = ~frame_sel_q;
              swap_ack_d  = 1'b1;
            end
            state_d = en_i ? StShift : StIdle;
          end else begin
            row_d   = row_q + RowW'(1);
            state_d = StShift;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_rd_en_o = 1'b0;
    pix_col_o   = '0;
    panel_clk_o = 1'b0;
    lat_o       = 1'b0;
    oe_o        = 1'b1;
    unique case (state_q)
      StShift: begin
        pix_rd_en_o = !cnt_q[0] && cnt_q < CntW'(2 * COLS);
        pix_col_o   = pix_rd_en_o ? ColW'(cnt_q >> 1) : '0;
        panel_clk_o = cnt_q[0] && cnt_q >= CntW'(3);
      end
      StLatch: lat_o = 1'b1;
      StDisplay: begin
`ifdef SCAN_DIM_EN
        oe_o = (cnt_q >= on_len);
`else
        oe_o = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  assign pix_row_o    = row_q;
  assign row_addr_o   = row_addr_q;
  assign rgb0_o       = rgb0_q;
  assign rgb1_o       = rgb1_q;
  assign frame_sel_o  = frame_sel_q;
  assign swap_ack_o   = swap_ack_q;
  assign frame_done_o = frame_done_q;

endmodule
